// File: rtl/mem_wait_bridge_pkg.sv
`timescale 1ns/1ps
// mem_wait_bridge_pkg
// Shared types and helpers for the core-to-async-memory wait bridge:
//   state_e      - bridge FSM states (IDLE/RD/WR/DONE)
//   DEF_*        - default widths and wait counts
//   clamp_wait() - forces a wait count below 1 up to 1
//   max_int()    - larger of two ints, used to size the wait counter
package mem_wait_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_RD_WAIT = 3;
  localparam int DEF_WR_WAIT = 1;
  localparam int DEF_CNT_W   = 16;

  function automatic int clamp_wait(input int w);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/wait_counter.sv
`timescale 1ns/1ps
// wait_counter
// Loadable down-counter that times how long the memory enables are held.
// Ports:
//   clk, reset : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (has priority over en)
//   load_val   : value to load
//   en         : decrement by one, saturating at zero
//   zero       : count is zero
module wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/mem_wait_bridge.sv
`timescale 1ns/1ps
// mem_wait_bridge
// Bridges the multi-cycle core's request/ready memory port to an
// asynchronous word memory. Each request is latched, address/data are held
// stable with the enable asserted for RD_WAIT / WR_WAIT cycles, read data is
// captured once settled, and cpu_ready pulses for one cycle in DONE.
// Wrapping read/write completion counters are kept for the benches.
//
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   cpu_read, cpu_write        : core requests, held until cpu_ready
//   cpu_addr, cpu_wdata        : core byte address / write data
//   cpu_rdata, cpu_ready       : registered read data / completion pulse
//   mem_read, mem_write        : registered memory enables
//   mem_addr, mem_write_data   : latched address / write data
//   mem_read_data              : asynchronous memory read data
//   rd_count, wr_count         : completed reads / writes, wrapping
//   cpu_misaligned             : only with MEM_WAIT_BRIDGE_ALIGN_CHECK_EN;
//                                flags a request rejected for addr[1:0] != 0
//
// Build option: define MEM_WAIT_BRIDGE_ALIGN_CHECK_EN to enable the
// alignment check and its cpu_misaligned port.
module mem_wait_bridge
  import mem_wait_bridge_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RD_WAIT = DEF_RD_WAIT,
  parameter int WR_WAIT = DEF_WR_WAIT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
`ifdef MEM_WAIT_BRIDGE_ALIGN_CHECK_EN
  ,
  output logic              cpu_misaligned
`endif
);

  localparam int RD_CYC = clamp_wait(RD_WAIT);
  localparam int WR_CYC = clamp_wait(WR_WAIT);
  localparam int CW     = $clog2(max_int(RD_CYC, WR_CYC) + 1);
  localparam logic [CW-1:0] RD_LOAD = CW'(RD_CYC - 1);
  localparam logic [CW-1:0] WR_LOAD = CW'(WR_CYC - 1);

  state_e state_q, state_d;

  logic              mem_read_q,  mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic [DATA_W-1:0] rdata_q,     rdata_d;
  logic [CNT_W-1:0]  rd_cnt_q,    rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q,    wr_cnt_d;
`ifdef MEM_WAIT_BRIDGE_ALIGN_CHECK_EN
  logic              mis_q,       mis_d;
`endif

  logic          req;
  logic          bad_align;
  logic          cnt_load;
  logic [CW-1:0] cnt_load_val;
  logic          cnt_en;
  logic          cnt_zero;

  assign req = cpu_read | cpu_write;

`ifdef MEM_WAIT_BRIDGE_ALIGN_CHECK_EN
  assign bad_align = (cpu_addr[1:0] != 2'b00);
`else
  assign bad_align = 1'b0;
`endif

  wait_counter #(.W(CW)) u_wait_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; write wins when both requests are high
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (bad_align) begin
            state_d = DONE;
          end else if (cpu_write) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD, WR: begin
        if (cnt_zero) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values. The registered enables simply follow
  // the next state, so they rise on the sample edge and fall on the
  // completion edge (or on reset).
  always_comb begin
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    cnt_load     = 1'b0;
    cnt_load_val = RD_LOAD;
    cnt_en       = 1'b0;
    mem_read_d   = (state_d == RD);
    mem_write_d  = (state_d == WR);
`ifdef MEM_WAIT_BRIDGE_ALIGN_CHECK_EN
    mis_d        = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (bad_align) begin
`ifdef MEM_WAIT_BRIDGE_ALIGN_CHECK_EN
            mis_d = 1'b1;
`endif
          end else begin
            addr_d       = cpu_addr;
            wdata_d      = cpu_wdata;
            cnt_load     = 1'b1;
            cnt_load_val = cpu_write ? WR_LOAD : RD_LOAD;
          end
        end
      end
      RD: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          rdata_d  = mem_read_data;
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
        end
      end
      WR: begin
        cnt_en = 1'b1;
        if (cnt_zero) begin
          wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
`ifdef MEM_WAIT_BRIDGE_ALIGN_CHECK_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
`ifdef MEM_WAIT_BRIDGE_ALIGN_CHECK_EN
      mis_q       <= mis_d;
`endif
    end
  end

  assign cpu_ready      = (state_q == DONE);
  assign cpu_rdata      = rdata_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_addr       = addr_q;
  assign mem_write_data = wdata_q;
  assign rd_count       = rd_cnt_q;
  assign wr_count       = wr_cnt_q;
`ifdef MEM_WAIT_BRIDGE_ALIGN_CHECK_EN
  assign cpu_misaligned = mis_q;
`endif

endmodule

// File: tb/tb_mem_wait_bridge.sv
`timescale 1ns/1ps
// Bench for mem_wait_bridge: directed vector table, hand-written corner
// sequences and randomized transactions against a word-memory model.
module tb_mem_wait_bridge;

  localparam int RDW = 3;
  localparam int WRW = 1;
  localparam int CW  = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ready, mem_read, mem_write;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic [CW-1:0] rd_count, wr_count;
`ifdef MEM_WAIT_BRIDGE_ALIGN_CHECK_EN
  logic        cpu_misaligned;
`endif

  mem_wait_bridge #(
    .ADDR_W(32), .DATA_W(32), .RD_WAIT(RDW), .WR_WAIT(WRW), .CNT_W(CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_ready      (cpu_ready),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .rd_count       (rd_count),
    .wr_count       (wr_count)
`ifdef MEM_WAIT_BRIDGE_ALIGN_CHECK_EN
    ,
    .cpu_misaligned (cpu_misaligned)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    if (i == 5) return 32'hDEADBEEF;
    return 32'(i * 32'h0101_0101) ^ 32'h5A00_0000;
  endfunction

  // Asynchronous word memory: byte address bits [1:0] ignored
  logic [31:0] mem [0:255];
  bit mem_init_done = 1'b0;
  assign mem_read_data = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_init_done <= 1'b1;
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_write_data;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:255];
  int          m_rd, m_wr;
  logic [31:0] m_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkint(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one request from IDLE, wait (bounded) for cpu_ready, then drop the
  // request and let the bridge return to IDLE. Core inputs are scrambled
  // while waiting to show the latched values do not move.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat,
                         output int rdcyc, output int wrcyc,
                         output bit stable, output bit mis_seen);
    bit got;
    cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata;
    lat = 0; rdcyc = 0; wrcyc = 0; stable = 1'b1; mis_seen = 1'b0; got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      lat++;
      if (mem_read)  rdcyc++;
      if (mem_write) wrcyc++;
      if ((mem_read || mem_write) &&
          (mem_addr !== addr || (wr && mem_write_data !== wdata)))
        stable = 1'b0;
      if (cpu_ready) begin
`ifdef MEM_WAIT_BRIDGE_ALIGN_CHECK_EN
        mis_seen = cpu_misaligned;
`endif
        got = 1'b1;
        break;
      end
      cpu_addr = $urandom; cpu_wdata = $urandom;
    end
    if (!got) lat = -1;
    cpu_read = 1'b0; cpu_write = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_rdcyc;
    int          exp_wrcyc;
  } vec_t;

  vec_t vecs [5];

  int lat, rdcyc, wrcyc, hold_lat;
  bit stable, mis_seen, ok;
  int idx;
  bit rd, wr;
  logic [31:0] wd;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'h14, 32'h0,        32'hDEADBEEF, 4, 3, 0};
    vecs[1] = '{1'b0, 1'b1, 32'hC8, 32'h12345678, 32'hDEADBEEF, 2, 0, 1};
    vecs[2] = '{1'b1, 1'b0, 32'hC8, 32'h0,        32'h12345678, 4, 3, 0};
    vecs[3] = '{1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 32'h12345678, 2, 0, 1};
    vecs[4] = '{1'b1, 1'b0, 32'h20, 32'h0,        32'hA5A5A5A5, 4, 3, 0};
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

    reset = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check32("rst_ready",   {31'b0, cpu_ready}, 32'd0);
    check32("rst_mem_read",{31'b0, mem_read},  32'd0);
    check32("rst_mem_wr",  {31'b0, mem_write}, 32'd0);
    check32("rst_addr",    mem_addr,           32'd0);
    check32("rst_wdata",   mem_write_data,     32'd0);
    check32("rst_rdata",   cpu_rdata,          32'd0);
    check32("rst_counts",  {24'b0, rd_count, wr_count}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    for (int v = 0; v < 5; v++) begin
      run_txn(vecs[v].rd, vecs[v].wr, vecs[v].addr, vecs[v].wdata,
              lat, rdcyc, wrcyc, stable, mis_seen);
      checkint($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      checkint($sformatf("vec%0d_rd_cycles", v), rdcyc, vecs[v].exp_rdcyc);
      checkint($sformatf("vec%0d_wr_cycles", v), wrcyc, vecs[v].exp_wrcyc);
      checkint($sformatf("vec%0d_stable", v), int'(stable), 1);
      check32($sformatf("vec%0d_rdata", v), cpu_rdata, vecs[v].exp_rdata);
`ifdef MEM_WAIT_BRIDGE_ALIGN_CHECK_EN
      checkint($sformatf("vec%0d_misaligned", v), int'(mis_seen), 0);
`endif
    end
    check32("mem50", mem[50], 32'h12345678);
    check32("mem8",  mem[8],  32'hA5A5A5A5);
    checkint("table_rd_count", int'(rd_count), 3);
    checkint("table_wr_count", int'(wr_count), 2);
    ref_mem[50] = 32'h12345678;
    ref_mem[8]  = 32'hA5A5A5A5;
    m_rd = 3; m_wr = 2; m_rdata = 32'hA5A5A5A5;

    // Request held through DONE is ignored there, but re-sampled in IDLE
    cpu_read = 1'b1; cpu_addr = 32'h14;
    ok = 1'b0; hold_lat = 0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(posedge clk); #1; hold_lat++;
      if (cpu_ready) ok = 1'b1;
    end
    checkint("hold_first_latency", ok ? hold_lat : -1, RDW + 1);
    @(posedge clk); #1;
    check32("hold_done_ignored", {30'b0, mem_read, cpu_ready}, 32'd0);
    @(posedge clk); #1;
    check32("hold_idle_resample", {31'b0, mem_read}, 32'd1);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (cpu_ready) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    checkint("hold_second_done", int'(ok), 1);
    cpu_read = 1'b0;
    @(posedge clk); #1;
    m_rd += 2; m_rdata = 32'hDEADBEEF;
    checkint("hold_rd_count", int'(rd_count), m_rd % 16);
    check32("hold_rdata", cpu_rdata, m_rdata);

    // Unaligned address
    run_txn(1'b1, 1'b0, 32'h15, 32'h0, lat, rdcyc, wrcyc, stable, mis_seen);
`ifdef MEM_WAIT_BRIDGE_ALIGN_CHECK_EN
    checkint("mis_latency", lat, 1);
    checkint("mis_flag", int'(mis_seen), 1);
    checkint("mis_rd_cycles", rdcyc, 0);
    check32("mis_rdata", cpu_rdata, m_rdata);
`else
    checkint("unaligned_latency", lat, RDW + 1);
    check32("unaligned_rdata", cpu_rdata, ref_mem[5]);
    m_rd++; m_rdata = ref_mem[5];
`endif
    checkint("unaligned_rd_count", int'(rd_count), m_rd % 16);

    // Reset during the second RD cycle
    cpu_read = 1'b1; cpu_addr = 32'h40;
    @(posedge clk); #1;
    check32("rstmid_rd_cycle1", {31'b0, mem_read}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1; cpu_read = 1'b0;
    @(posedge clk); #1;
    check32("rstmid_mem_read", {31'b0, mem_read}, 32'd0);
    check32("rstmid_ready",    {31'b0, cpu_ready}, 32'd0);
    checkint("rstmid_rd_count", int'(rd_count), 0);
    check32("rstmid_rdata", cpu_rdata, 32'd0);
    reset = 1'b0;
    ok = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (cpu_ready || mem_read) ok = 1'b1;
    end
    checkint("rstmid_no_ready", int'(ok), 0);
    m_rd = 0; m_wr = 0; m_rdata = '0;

    // Counter wrap: 17 reads with a 4-bit counter
    for (int n = 0; n < 17; n++) begin
      idx = $urandom_range(0, 255);
      run_txn(1'b1, 1'b0, 32'(idx) << 2, 32'h0, lat, rdcyc, wrcyc, stable, mis_seen);
      check32($sformatf("wrap_rdata%0d", n), cpu_rdata, ref_mem[idx]);
      m_rd++; m_rdata = ref_mem[idx];
    end
    checkint("wrap_rd_count", int'(rd_count), 1);
    checkint("wrap_wr_count", int'(wr_count), 0);

    // Randomized transactions against the model
    for (int n = 0; n < 40; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      if (!rd && !wr) rd = 1'b1;
      idx = $urandom_range(0, 255);
      wd = $urandom;
      run_txn(rd, wr, 32'(idx) << 2, wd, lat, rdcyc, wrcyc, stable, mis_seen);
      if (wr) begin
        ref_mem[idx] = wd;
        m_wr++;
        checkint($sformatf("rnd%0d_latency", n), lat, WRW + 1);
        checkint($sformatf("rnd%0d_wr_cycles", n), wrcyc, WRW);
        checkint($sformatf("rnd%0d_rd_cycles", n), rdcyc, 0);
        check32($sformatf("rnd%0d_mem", n), mem[idx], ref_mem[idx]);
      end else begin
        m_rd++;
        m_rdata = ref_mem[idx];
        checkint($sformatf("rnd%0d_latency", n), lat, RDW + 1);
        checkint($sformatf("rnd%0d_rd_cycles", n), rdcyc, RDW);
        checkint($sformatf("rnd%0d_wr_cycles", n), wrcyc, 0);
      end
      checkint($sformatf("rnd%0d_stable", n), int'(stable), 1);
      check32($sformatf("rnd%0d_rdata", n), cpu_rdata, m_rdata);
      checkint($sformatf("rnd%0d_rd_count", n), int'(rd_count), m_rd % 16);
      checkint($sformatf("rnd%0d_wr_count", n), int'(wr_count), m_wr % 16);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
